// File: rtl/al_fifo_pkg.sv
// Shared helpers for the al_* FIFO family.
// Holds the output-mode names and elaboration-time sizing checks.
package al_fifo_pkg;

  localparam string REGMODE_NOREG  = "NOREG";
  localparam string REGMODE_OUTREG = "OUTREG";

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic bit levels_ok(
    input int ae,
    input int af,
    input int depth
  );
    return (ae >= 0) && (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/al_syn_sync_fifo_if.sv
// Bus bundle between a FIFO user and al_syn_sync_fifo.
// The master side writes/reads; the slave side is the FIFO itself.
interface al_syn_sync_fifo_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 9
) ();

  logic [DATA_WIDTH-1:0] din;
  logic                  we;
  logic                  re;
  logic                  ore;
  logic                  flush;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty_flag;
  logic                  aempty_flag;
  logic                  afull_flag;
  logic                  full_flag;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din, we, re, ore, flush,
    input  dout, dout_valid, count,
    input  empty_flag, aempty_flag,
    input  afull_flag, full_flag,
    input  overflow, underflow
  );

  modport slave (
    input  din, we, re, ore, flush,
    output dout, dout_valid, count,
    output empty_flag, aempty_flag,
    output afull_flag, full_flag,
    output overflow, underflow
  );

endinterface

// File: rtl/al_syn_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset; the array itself is left untouched.
module al_syn_sdp_ram #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/al_syn_sync_fifo.sv
// Single-clock FIFO with programmable levels, flush and sticky errors.
// Optional second output register is gated by ore.
module al_syn_sync_fifo
  import al_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH = 18,
  parameter int    ADDR_WIDTH = 9,
  parameter string REGMODE    = "NOREG",
  parameter int    AE_LEVEL   = 4,
  parameter int    AF_LEVEL   = (1 << ADDR_WIDTH) - 4
) (
  input logic clk,
  input logic rst,
  al_syn_sync_fifo_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = clog2(DEPTH + 1);

  localparam logic [CW-1:0] AE_L   = CW'(AE_LEVEL);
  localparam logic [CW-1:0] AF_L   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  localparam bit OREG = (REGMODE == REGMODE_OUTREG);

  if (!levels_ok(AE_LEVEL, AF_LEVEL, DEPTH)) begin : g_lvl_err
    $error("al_syn_sync_fifo: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  if (REGMODE != REGMODE_NOREG && !OREG) begin : g_mode_err
    $error("al_syn_sync_fifo: REGMODE must be NOREG or OUTREG");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  empty_q, aempty_q;
  logic                  afull_q, full_q;
  logic                  ovf_q, unf_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] q;
  logic                  v1;

  // Acceptance uses registered flags only, so no same-cycle bypass exists.
  always_comb begin
    wr_acc  = bus.we & ~full_q & ~bus.flush;
    rd_acc  = bus.re & ~empty_q & ~bus.flush;
    cnt_nxt = cnt + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      cnt      <= cnt_nxt;
      empty_q  <= (cnt_nxt == '0);
      aempty_q <= (cnt_nxt <= AE_L);
      afull_q  <= (cnt_nxt >= AF_L);
      full_q   <= (cnt_nxt == FULL_C);
      if (bus.we & full_q)  ovf_q <= 1'b1;
      if (bus.re & empty_q) unf_q <= 1'b1;
    end
  end

  al_syn_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (q)
  );

  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else     v1 <= rd_acc;
  end

  if (OREG) begin : g_outreg
    logic                  s1_full;
    logic                  load2;
    logic                  v2;
    logic [DATA_WIDTH-1:0] s2;

    assign load2 = bus.ore & s1_full & ~bus.flush;

    // Stage 1 may be overwritten while ore is low; that data is dropped.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_full <= 1'b0;
        s2      <= '0;
        v2      <= 1'b0;
      end else begin
        if (bus.flush)  s1_full <= 1'b0;
        else if (rd_acc) s1_full <= 1'b1;
        else if (load2)  s1_full <= 1'b0;
        if (load2) s2 <= q;
        v2 <= load2;
      end
    end

    assign bus.dout       = s2;
    assign bus.dout_valid = v2;
  end else begin : g_noreg
    assign bus.dout       = q;
    assign bus.dout_valid = v1;
  end

  assign bus.count       = cnt;
  assign bus.empty_flag  = empty_q;
  assign bus.aempty_flag = aempty_q;
  assign bus.afull_flag  = afull_q;
  assign bus.full_flag   = full_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_al_syn_sync_fifo.sv
// Directed bench for al_syn_sync_fifo: one NOREG and one OUTREG instance.
// Both are 18 bits x 16 entries with AE=2, AF=14.
module tb_al_syn_sync_fifo;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  al_syn_sync_fifo_if #(.DATA_WIDTH(18), .ADDR_WIDTH(4)) ba ();
  al_syn_sync_fifo_if #(.DATA_WIDTH(18), .ADDR_WIDTH(4)) bb ();

  al_syn_sync_fifo #(
    .DATA_WIDTH(18), .ADDR_WIDTH(4), .REGMODE("NOREG"),
    .AE_LEVEL(2), .AF_LEVEL(14)
  ) u_a (.clk(clk), .rst(rst_a), .bus(ba));

  al_syn_sync_fifo #(
    .DATA_WIDTH(18), .ADDR_WIDTH(4), .REGMODE("OUTREG"),
    .AE_LEVEL(2), .AF_LEVEL(14)
  ) u_b (.clk(clk), .rst(rst_b), .bus(bb));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1; rst_b = 1;
    ba.din = '0; ba.we = 0; ba.re = 0; ba.ore = 0; ba.flush = 0;
    bb.din = '0; bb.we = 0; bb.re = 0; bb.ore = 0; bb.flush = 0;
    tick(); tick();
    n_cmp++; if (ba.count !== 5'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", ba.count); end
    n_cmp++; if (ba.empty_flag !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %b want 1", ba.empty_flag); end
    n_cmp++; if (ba.aempty_flag !== 1'b1) begin n_bad++; $display("FAIL rst_aempty got %b want 1", ba.aempty_flag); end
    n_cmp++; if (ba.afull_flag !== 1'b0) begin n_bad++; $display("FAIL rst_afull got %b want 0", ba.afull_flag); end
    n_cmp++; if (ba.full_flag !== 1'b0) begin n_bad++; $display("FAIL rst_full got %b want 0", ba.full_flag); end
    n_cmp++; if (ba.overflow !== 1'b0 || ba.underflow !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b%b want 00", ba.overflow, ba.underflow); end
    n_cmp++; if (ba.dout !== 18'h0 || ba.dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dout got %h/%b want 0/0", ba.dout, ba.dout_valid); end
    n_cmp++; if (bb.dout !== 18'h0 || bb.dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dout_b got %h/%b want 0/0", bb.dout, bb.dout_valid); end
    rst_a = 0; rst_b = 0;
    tick();
  endtask

  task automatic test_fill();
    logic ae, af, fl;
    for (int i = 1; i <= 16; i++) begin
      ba.we = 1; ba.din = 18'(i);
      tick();
      ae = (i <= 2); af = (i >= 14); fl = (i == 16);
      n_cmp++; if (ba.count !== 5'(i)) begin n_bad++; $display("FAIL fill_count[%0d] got %0d want %0d", i, ba.count, i); end
      n_cmp++; if (ba.aempty_flag !== ae) begin n_bad++; $display("FAIL fill_aempty[%0d] got %b want %b", i, ba.aempty_flag, ae); end
      n_cmp++; if (ba.afull_flag !== af) begin n_bad++; $display("FAIL fill_afull[%0d] got %b want %b", i, ba.afull_flag, af); end
      n_cmp++; if (ba.full_flag !== fl) begin n_bad++; $display("FAIL fill_full[%0d] got %b want %b", i, ba.full_flag, fl); end
      n_cmp++; if (ba.empty_flag !== 1'b0) begin n_bad++; $display("FAIL fill_empty[%0d] got %b want 0", i, ba.empty_flag); end
    end
    ba.din = 18'h11;
    tick();
    ba.we = 0;
    n_cmp++; if (ba.count !== 5'd16) begin n_bad++; $display("FAIL ovf_count got %0d want 16", ba.count); end
    n_cmp++; if (ba.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", ba.overflow); end
  endtask

  task automatic test_drain_noreg();
    ba.re = 1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++; if (ba.dout !== 18'(k) || ba.dout_valid !== 1'b1) begin n_bad++; $display("FAIL drain_dout[%0d] got %h/%b want %h/1", k, ba.dout, ba.dout_valid, k); end
      n_cmp++; if (ba.count !== 5'(16 - k)) begin n_bad++; $display("FAIL drain_count[%0d] got %0d want %0d", k, ba.count, 16 - k); end
    end
    ba.re = 0;
    n_cmp++; if (ba.empty_flag !== 1'b1) begin n_bad++; $display("FAIL drain_empty got %b want 1", ba.empty_flag); end
    tick();
    n_cmp++; if (ba.dout !== 18'h10 || ba.dout_valid !== 1'b0) begin n_bad++; $display("FAIL drain_hold got %h/%b want 10/0", ba.dout, ba.dout_valid); end
    n_cmp++; if (ba.underflow !== 1'b0) begin n_bad++; $display("FAIL unf_pre got %b want 0", ba.underflow); end
    ba.re = 1;
    tick();
    ba.re = 0;
    n_cmp++; if (ba.underflow !== 1'b1) begin n_bad++; $display("FAIL unf_flag got %b want 1", ba.underflow); end
    n_cmp++; if (ba.dout_valid !== 1'b0 || ba.count !== 5'd0) begin n_bad++; $display("FAIL unf_state got %b/%0d want 0/0", ba.dout_valid, ba.count); end
    n_cmp++; if (ba.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", ba.overflow); end
  endtask

  task automatic test_simultaneous();
    logic [17:0] exp_q[$];
    logic [17:0] e;
    ba.flush = 1;
    tick();
    ba.flush = 0;
    n_cmp++; if (ba.overflow !== 1'b0 || ba.underflow !== 1'b0) begin n_bad++; $display("FAIL flush_err got %b%b want 00", ba.overflow, ba.underflow); end
    for (int i = 0; i < 16; i++) begin
      ba.we = 1; ba.din = 18'(32 + i);
      tick();
      exp_q.push_back(18'(32 + i));
    end
    ba.re = 1; ba.din = 18'h3FFFF;
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (ba.dout !== e || ba.dout_valid !== 1'b1) begin n_bad++; $display("FAIL full_rw_dout got %h/%b want %h/1", ba.dout, ba.dout_valid, e); end
    n_cmp++; if (ba.count !== 5'd15) begin n_bad++; $display("FAIL full_rw_count got %0d want 15", ba.count); end
    n_cmp++; if (ba.overflow !== 1'b1 || ba.full_flag !== 1'b0) begin n_bad++; $display("FAIL full_rw_flags got %b/%b want 1/0", ba.overflow, ba.full_flag); end
    ba.we = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (ba.dout !== e) begin n_bad++; $display("FAIL rd_only[%0d] got %h want %h", i, ba.dout, e); end
    end
    n_cmp++; if (ba.count !== 5'd5) begin n_bad++; $display("FAIL rd_only_count got %0d want 5", ba.count); end
    ba.we = 1;
    for (int j = 0; j < 10; j++) begin
      ba.din = 18'(256 + j);
      tick();
      exp_q.push_back(18'(256 + j));
      e = exp_q.pop_front();
      n_cmp++; if (ba.dout !== e || ba.dout_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_rw[%0d] got %h want %h", j, ba.dout, e); end
      n_cmp++; if (ba.count !== 5'd5) begin n_bad++; $display("FAIL wrap_count[%0d] got %0d want 5", j, ba.count); end
    end
    ba.we = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (ba.dout !== e) begin n_bad++; $display("FAIL wrap_drain[%0d] got %h want %h", i, ba.dout, e); end
    end
    ba.re = 0;
    n_cmp++; if (ba.empty_flag !== 1'b1 || ba.count !== 5'd0) begin n_bad++; $display("FAIL wrap_empty got %b/%0d want 1/0", ba.empty_flag, ba.count); end
  endtask

  task automatic test_outreg();
    bb.we = 1; bb.din = 18'h155;
    tick();
    bb.din = 18'h0AA;
    tick();
    bb.we = 0; bb.ore = 1; bb.re = 1;
    tick();
    bb.re = 0;
    n_cmp++; if (bb.dout_valid !== 1'b0 || bb.dout !== 18'h0) begin n_bad++; $display("FAIL oreg_lat1 got %h/%b want 0/0", bb.dout, bb.dout_valid); end
    tick();
    n_cmp++; if (bb.dout !== 18'h155 || bb.dout_valid !== 1'b1) begin n_bad++; $display("FAIL oreg_lat2 got %h/%b want 155/1", bb.dout, bb.dout_valid); end
    bb.ore = 0; bb.re = 1;
    tick();
    bb.re = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bb.dout !== 18'h155 || bb.dout_valid !== 1'b0) begin n_bad++; $display("FAIL oreg_hold[%0d] got %h/%b want 155/0", i, bb.dout, bb.dout_valid); end
      if (i < 2) tick();
    end
    bb.ore = 1;
    tick();
    n_cmp++; if (bb.dout !== 18'h0AA || bb.dout_valid !== 1'b1) begin n_bad++; $display("FAIL oreg_release got %h/%b want 0aa/1", bb.dout, bb.dout_valid); end
    tick();
    n_cmp++; if (bb.dout_valid !== 1'b0 || bb.empty_flag !== 1'b1) begin n_bad++; $display("FAIL oreg_done got %b/%b want 0/1", bb.dout_valid, bb.empty_flag); end
  endtask

  task automatic test_flush();
    ba.re = 1;
    tick();
    ba.re = 0;
    n_cmp++; if (ba.underflow !== 1'b1) begin n_bad++; $display("FAIL fl_unf_set got %b want 1", ba.underflow); end
    for (int i = 0; i < 7; i++) begin
      ba.we = 1; ba.din = 18'(64 + i);
      tick();
    end
    ba.re = 1; ba.din = 18'h47;
    tick();
    n_cmp++; if (ba.dout !== 18'h40 || ba.count !== 5'd7) begin n_bad++; $display("FAIL fl_pre got %h/%0d want 40/7", ba.dout, ba.count); end
    ba.flush = 1; ba.din = 18'h3AB;
    tick();
    ba.flush = 0; ba.re = 0;
    n_cmp++; if (ba.count !== 5'd0 || ba.empty_flag !== 1'b1) begin n_bad++; $display("FAIL fl_count got %0d/%b want 0/1", ba.count, ba.empty_flag); end
    n_cmp++; if (ba.aempty_flag !== 1'b1 || ba.underflow !== 1'b0) begin n_bad++; $display("FAIL fl_flags got %b/%b want 1/0", ba.aempty_flag, ba.underflow); end
    n_cmp++; if (ba.dout !== 18'h40 || ba.dout_valid !== 1'b0) begin n_bad++; $display("FAIL fl_dout got %h/%b want 40/0", ba.dout, ba.dout_valid); end
    ba.din = 18'h77;
    tick();
    ba.we = 0;
    n_cmp++; if (ba.count !== 5'd1) begin n_bad++; $display("FAIL fl_nowrite got %0d want 1", ba.count); end
    ba.re = 1;
    tick();
    ba.re = 0;
    n_cmp++; if (ba.dout !== 18'h77 || ba.dout_valid !== 1'b1) begin n_bad++; $display("FAIL fl_after got %h/%b want 77/1", ba.dout, ba.dout_valid); end
  endtask

  task automatic test_reset_outreg();
    bb.we = 1; bb.din = 18'h1;
    tick();
    bb.din = 18'h2;
    tick();
    bb.we = 0; bb.ore = 1; bb.re = 1;
    tick();
    bb.re = 0; rst_b = 1;
    tick();
    rst_b = 0;
    n_cmp++; if (bb.dout !== 18'h0 || bb.dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid got %h/%b want 0/0", bb.dout, bb.dout_valid); end
    n_cmp++; if (bb.count !== 5'd0 || bb.empty_flag !== 1'b1) begin n_bad++; $display("FAIL rst_mid_cnt got %0d/%b want 0/1", bb.count, bb.empty_flag); end
    tick();
    n_cmp++; if (bb.dout !== 18'h0 || bb.dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_after got %h/%b want 0/0", bb.dout, bb.dout_valid); end
    bb.ore = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_noreg();
    test_simultaneous();
    test_outreg();
    test_flush();
    test_reset_outreg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
